dog_frame_sequencer: RTL and testbench
======================================

// Module: dog_frame_sequencer
// PURPOSE
// - Sequences one SIFT frame through the DoG pyramid datapath: fetches pixels from frame memory,
//   streams them to DoG (din) one per cycle, one full pass per octave, waits for DoG completion.
// - Octave o reads every (1<<o)-th pixel of every (1<<o)-th row (decimation by address stride).
// - Sits between frame buffer read port and DoG input; top-level FSM pulses start once per frame.
// PARAMETERS
// - IMG_W    640   image width in pixels (power of 2 not required; must be even)
// - IMG_H    480   image height in rows (must be even)
// - ADDR_W   21    frame memory address width
// - PIX_W    8     pixel width
// - OCTAVES  2     octaves per frame (1..4)
// - TIMEOUT  65535 max cycles in WAIT_CMP before error
// PORTS
// - clk          in   1       system clock
// - rst          in   1       asynchronous reset, active low
// - start        in   1       1-cycle pulse; begins frame when idle
// - abort        in   1       synchronous abort; return to IDLE
// - mem_rd       out  1       frame memory read strobe
// - mem_addr     out  ADDR_W  frame memory read address
// - mem_rdata    in   PIX_W   read data, valid exactly 1 cycle after mem_rd
// - dog_din      out  PIX_W   pixel to DoG
// - dog_valid    out  1       dog_din valid
// - dog_sof      out  1       marks first pixel of each octave pass (with dog_valid)
// - dog_octave   out  2       octave index of current pass
// - dog_complete in   1       DoG pass-finished pulse (complete1/complete2 ORed at top)
// - busy         out  1       high from accepted start until DONE/IDLE
// - done         out  1       1-cycle pulse: all octaves completed
// - err_timeout  out  1       1-cycle pulse: WAIT_CMP exceeded TIMEOUT
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; every output 0; counters, octave index 0.
// - States: IDLE, FETCH, FLUSH, WAIT_CMP, NEXT_OCT, DONE.
// - IDLE: start=1 -> FETCH, octave 0, row/col 0. start while not IDLE ignored.
// - FETCH: mem_rd=1 every cycle; addr = row_base + col; col += s (s=1<<o) up to IDLE_W-s,
//   then col=0, row_base += s*IMG_W (incremental add, no multiplier). Pass reads
//   (IMG_W>>o)*(IMG_H>>o) pixels. After last read -> FLUSH.
// - Output pipe: dog_valid = mem_rd delayed 1; dog_din = mem_rdata; dog_sof on first valid of pass.
// - FLUSH: 1 cycle (last pixel emerges) -> WAIT_CMP.
// - WAIT_CMP: counts cycles; dog_complete=1 -> NEXT_OCT; count==TIMEOUT -> err_timeout pulse, IDLE.
//   dog_complete outside WAIT_CMP ignored.
// - NEXT_OCT: o+1; o+1==OCTAVES -> DONE else FETCH (row/col cleared) next cycle.
// - DONE: done=1 one cycle -> IDLE. busy=0 in IDLE only.
// - abort=1 in any state: next cycle IDLE, mem_rd=0, dog_valid=0 (in-flight read discarded),
//   no done/err pulse. abort has priority over start and dog_complete same cycle.
// - mem_addr holds last value when mem_rd=0; dog_octave stable for whole pass.
// STRUCTURE
// - sift_pkg: state enum, IMG_W/IMG_H/ADDR_W defaults, octave index width constant.
// - Sub-module dog_addr_gen: stride-aware col/row_base counters, last-pixel flag; FSM in top.
// TESTING (IMG_W=8, IMG_H=4, OCTAVES=2, TIMEOUT=16, mem model returns data=addr[7:0])
// - start -> 32 reads addr 0..31, dog_din 0..31 one cycle later, dog_sof with din=0; complete ->
//   octave 1 reads 0,2,4,6,16,18,20,22, dog_octave=1; complete -> done pulse, busy=0.
// - hold dog_complete low 5 cycles in WAIT_CMP -> no reads; pulse -> FETCH starts next+1 cycle.
// - never complete -> err_timeout pulse after 16 WAIT_CMP cycles, busy=0, no done.
// - abort at 10th read -> next cycle mem_rd=0, dog_valid=0, busy=0; new start restarts at addr 0.
// - rst low mid-FETCH -> all outputs 0 immediately (async), IDLE after release.
// - start during busy and dog_complete while IDLE -> ignored; read sequence/state unchanged.

Source files
------------

// File: rtl/sift_pkg.sv
// Shared types and default geometry for the SIFT DoG front end.
package sift_pkg;

  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int ADDR_W_DEF = 21;
  localparam int PIX_W_DEF  = 8;

  // Octave index width: up to 4 octaves per frame.
  localparam int OCT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FLUSH,
    ST_WAIT_CMP,
    ST_NEXT_OCT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/dog_addr_gen.sv
// Stride-aware frame address generator: walks every (1<<octave)-th pixel of
// every (1<<octave)-th row using only adds and shifts.
module dog_addr_gen import sift_pkg::*; #(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [OCT_W-1:0]  octave,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] ccnt_q, ccnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] stride, row_step, col_last, row_last;
  logic              col_end;

  // Per-octave geometry: stride, row step and per-pass pixel/row counts.
  always_comb begin
    stride   = ADDR_W'(1) << octave;
    row_step = ADDR_W'(IMG_W) << octave;
    col_last = (ADDR_W'(IMG_W) >> octave) - ADDR_W'(1);
    row_last = (ADDR_W'(IMG_H) >> octave) - ADDR_W'(1);
    col_end  = (ccnt_q == col_last);
    last     = col_end && (rcnt_q == row_last);
    first    = (ccnt_q == '0) && (rcnt_q == '0);
    addr     = row_base_q + col_q;
  end

  // Counter advance: column steps by stride, row base steps by a full decimated row.
  always_comb begin
    col_d      = col_q;
    row_base_d = row_base_q;
    ccnt_d     = ccnt_q;
    rcnt_d     = rcnt_q;
    if (clr) begin
      col_d      = '0;
      row_base_d = '0;
      ccnt_d     = '0;
      rcnt_d     = '0;
    end else if (adv) begin
      if (col_end) begin
        col_d      = '0;
        ccnt_d     = '0;
        row_base_d = row_base_q + row_step;
        rcnt_d     = rcnt_q + ADDR_W'(1);
      end else begin
        col_d  = col_q + stride;
        ccnt_d = ccnt_q + ADDR_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      row_base_q <= '0;
      ccnt_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      col_q      <= col_d;
      row_base_q <= row_base_d;
      ccnt_q     <= ccnt_d;
      rcnt_q     <= rcnt_d;
    end
  end

endmodule

// File: rtl/dog_frame_sequencer.sv
// Sequences one frame through the DoG pyramid: one decimated read pass per
// octave, one-cycle read-data pipe to DoG, then waits for DoG completion.
module dog_frame_sequencer import sift_pkg::*; #(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int OCTAVES = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  dog_din,
  output logic              dog_valid,
  output logic              dog_sof,
  output logic [OCT_W-1:0]  dog_octave,
  input  logic              dog_complete,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam int                TO_W     = $clog2(TIMEOUT + 1);
  // Last WAIT_CMP cycle index before giving up (cycles counted from 0).
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [OCT_W-1:0]  OCT_LAST = OCT_W'(OCTAVES - 1);

  seq_state_e        state_q, state_d;
  logic [OCT_W-1:0]  octave_q, octave_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              dog_valid_q, dog_valid_d;
  logic              sof_q, sof_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;

  logic [ADDR_W-1:0] gen_addr;
  logic              gen_first, gen_last;
  logic              fetching;

  assign fetching = (state_q == ST_FETCH);

  // Counters sit at zero whenever not fetching, so every pass starts at pixel 0.
  dog_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (!fetching),
    .adv    (fetching),
    .octave (octave_q),
    .addr   (gen_addr),
    .first  (gen_first),
    .last   (gen_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_FETCH;
      ST_FETCH:    if (gen_last) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_WAIT_CMP;
      ST_WAIT_CMP: begin
        if (dog_complete)              state_d = ST_NEXT_OCT;
        else if (wait_cnt_q == TO_LAST) state_d = ST_IDLE;
      end
      ST_NEXT_OCT: state_d = (octave_q == OCT_LAST) ? ST_DONE : ST_FETCH;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    mem_rd = fetching;
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
  end

  // Datapath next values: octave index, wait counter, read pipe, address hold.
  always_comb begin
    octave_d    = octave_q;
    wait_cnt_d  = (state_q == ST_WAIT_CMP) ? wait_cnt_q + TO_W'(1) : '0;
    dog_valid_d = mem_rd && !abort;
    sof_d       = mem_rd && gen_first && !abort;
    err_d       = (state_q == ST_WAIT_CMP) && !dog_complete &&
                  (wait_cnt_q == TO_LAST) && !abort;
    addr_hold_d = mem_rd ? gen_addr : addr_hold_q;
    if (!abort) begin
      if (state_q == ST_IDLE && start)
        octave_d = '0;
      else if (state_q == ST_NEXT_OCT && octave_q != OCT_LAST)
        octave_d = octave_q + OCT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      octave_q    <= '0;
      wait_cnt_q  <= '0;
      dog_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_hold_q <= '0;
    end else begin
      octave_q    <= octave_d;
      wait_cnt_q  <= wait_cnt_d;
      dog_valid_q <= dog_valid_d;
      sof_q       <= sof_d;
      err_q       <= err_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  // Read data arrives one cycle after the strobe and goes straight to DoG.
  assign mem_addr    = mem_rd ? gen_addr : addr_hold_q;
  assign dog_valid   = dog_valid_q;
  assign dog_sof     = sof_q;
  assign dog_din     = dog_valid_q ? mem_rdata : '0;
  assign dog_octave  = octave_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_dog_frame_sequencer.sv
// Randomized bench for dog_frame_sequencer with a small frame geometry.
module tb_dog_frame_sequencer;

  localparam int W = 8, H = 4, AW = 21, PW = 8, OCT = 2, TO = 16;

  logic          clk = 1'b0, rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0, dog_complete = 1'b0;
  logic          mem_rd, dog_valid, dog_sof, busy, done, err_timeout;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rdata = '0;
  logic [PW-1:0] dog_din;
  logic [1:0]    dog_octave;
  logic [7:0]    key = 8'h00;
  int            checks = 0, failures = 0;

  dog_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW), .OCTAVES(OCT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dog_din(dog_din), .dog_valid(dog_valid), .dog_sof(dog_sof),
    .dog_octave(dog_octave), .dog_complete(dog_complete),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Frame memory: data = low address byte, optionally scrambled by key.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0] ^ key;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(negedge clk);
  endtask

  // One octave pass: reference address list from the decimation rule.
  task automatic check_pass(input int o, input bit noise);
    int  exp[$];
    int  s, n, ea;
    bit  er, ev;
    s = 1 << o;
    for (int r = 0; r < H; r += s)
      for (int c = 0; c < W; c += s)
        exp.push_back(r * W + c);
    n = exp.size();
    for (int i = 0; i <= n; i++) begin
      er = (i < n);
      ev = (i > 0);
      ea = er ? exp[i] : exp[n-1];
      checks++;
      if (mem_rd !== er) begin
        failures++; $display("FAIL pass_rd o=%0d i=%0d got=%0b exp=%0b", o, i, mem_rd, er);
      end
      checks++;
      if (mem_addr !== AW'(ea)) begin
        failures++; $display("FAIL pass_addr o=%0d i=%0d got=%0d exp=%0d", o, i, mem_addr, ea);
      end
      checks++;
      if (dog_valid !== ev) begin
        failures++; $display("FAIL pass_valid o=%0d i=%0d got=%0b exp=%0b", o, i, dog_valid, ev);
      end
      if (i > 0) begin
        checks++;
        if (dog_din !== (8'(exp[i-1]) ^ key)) begin
          failures++; $display("FAIL pass_din o=%0d i=%0d got=%0h exp=%0h", o, i, dog_din, 8'(exp[i-1]) ^ key);
        end
        checks++;
        if (dog_sof !== (i == 1)) begin
          failures++; $display("FAIL pass_sof o=%0d i=%0d got=%0b", o, i, dog_sof);
        end
        checks++;
        if (dog_octave !== 2'(o)) begin
          failures++; $display("FAIL pass_octave i=%0d got=%0d exp=%0d", i, dog_octave, o);
        end
      end
      checks++;
      if ({busy, done, err_timeout} !== 3'b100) begin
        failures++; $display("FAIL pass_status o=%0d i=%0d got=%b exp=100", o, i, {busy, done, err_timeout});
      end
      if (noise && i < n) begin
        start        = 1'($urandom_range(0, 1));
        dog_complete = ($urandom_range(0, 3) == 0);
      end else begin
        start        = 1'b0;
        dog_complete = 1'b0;
      end
      step;
    end
  endtask

  // WAIT_CMP for w idle cycles, then pulse complete; ends at the following state.
  task automatic wait_and_complete(input int w, input bit noise);
    for (int k = 0; k <= w; k++) begin
      checks++;
      if ({mem_rd, dog_valid, busy, done, err_timeout} !== 5'b00100) begin
        failures++; $display("FAIL wait k=%0d got=%b exp=00100", k, {mem_rd, dog_valid, busy, done, err_timeout});
      end
      if (k == w) begin start = 1'b0; dog_complete = 1'b1; end
      else start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step;
    end
    dog_complete = 1'b0;
    start        = 1'b0;
    checks++;
    if ({mem_rd, dog_valid, busy, done, err_timeout} !== 5'b00100) begin
      failures++; $display("FAIL next_oct got=%b exp=00100", {mem_rd, dog_valid, busy, done, err_timeout});
    end
    step;
  endtask

  task automatic finish_frame;
    checks++;
    if ({mem_rd, busy, done, err_timeout} !== 4'b0110) begin
      failures++; $display("FAIL done_pulse got=%b exp=0110", {mem_rd, busy, done, err_timeout});
    end
    step;
    checks++;
    if ({mem_rd, dog_valid, busy, done, err_timeout} !== 5'b00000) begin
      failures++; $display("FAIL after_done got=%b exp=00000", {mem_rd, dog_valid, busy, done, err_timeout});
    end
    step;
  endtask

  task automatic run_frame(input bit noise, input int w0, input int w1);
    start = 1'b1; step; start = 1'b0;
    check_pass(0, noise);
    wait_and_complete(w0, noise);
    check_pass(1, noise);
    wait_and_complete(w1, noise);
    finish_frame();
  endtask

  task automatic test_reset;
    step; step;
    checks++;
    if ({mem_rd, mem_addr, dog_din, dog_valid, dog_sof, dog_octave, busy, done, err_timeout} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0",
        {mem_rd, mem_addr, dog_din, dog_valid, dog_sof, dog_octave, busy, done, err_timeout});
    end
    rst = 1'b1; step;
    checks++;
    if ({mem_rd, busy, done} !== 3'b000) begin
      failures++; $display("FAIL reset_release got=%b exp=000", {mem_rd, busy, done});
    end
  endtask

  task automatic test_ignore_idle;
    dog_complete = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      checks++;
      if ({mem_rd, busy, done, err_timeout} !== 4'b0000) begin
        failures++; $display("FAIL idle_complete k=%0d got=%b exp=0000", k, {mem_rd, busy, done, err_timeout});
      end
    end
    dog_complete = 1'b0; step;
  endtask

  task automatic test_timeout;
    start = 1'b1; step; start = 1'b0;
    check_pass(0, 1'b0);
    for (int k = 0; k < TO; k++) begin
      checks++;
      if ({mem_rd, busy, done, err_timeout} !== 4'b0100) begin
        failures++; $display("FAIL to_wait k=%0d got=%b exp=0100", k, {mem_rd, busy, done, err_timeout});
      end
      step;
    end
    checks++;
    if ({mem_rd, busy, done, err_timeout} !== 4'b0001) begin
      failures++; $display("FAIL to_pulse got=%b exp=0001", {mem_rd, busy, done, err_timeout});
    end
    for (int k = 0; k < 4; k++) begin
      step;
      checks++;
      if ({mem_rd, busy, done, err_timeout} !== 4'b0000) begin
        failures++; $display("FAIL to_after k=%0d got=%b exp=0000", k, {mem_rd, busy, done, err_timeout});
      end
    end
  endtask

  task automatic test_abort(input int at);
    start = 1'b1; step; start = 1'b0;
    for (int i = 0; i <= at; i++) begin
      checks++;
      if ({mem_rd, mem_addr} !== {1'b1, AW'(i)}) begin
        failures++; $display("FAIL abort_pre i=%0d got=%0b/%0d exp=1/%0d", i, mem_rd, mem_addr, i);
      end
      if (i == at) begin abort = 1'b1; dog_complete = 1'b1; start = 1'b1; end
      step;
    end
    abort = 1'b0; dog_complete = 1'b0; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_rd, dog_valid, dog_sof, busy, done, err_timeout} !== 6'b0) begin
        failures++; $display("FAIL abort_idle k=%0d got=%b exp=000000", k, {mem_rd, dog_valid, dog_sof, busy, done, err_timeout});
      end
      step;
    end
  endtask

  // Abort in WAIT_CMP wins over a same-cycle complete: no next pass, no done.
  task automatic test_abort_wait;
    start = 1'b1; step; start = 1'b0;
    check_pass(0, 1'b0);
    step; step;
    abort = 1'b1; dog_complete = 1'b1; step;
    abort = 1'b0; dog_complete = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_rd, busy, done, err_timeout} !== 4'b0000) begin
        failures++; $display("FAIL abort_wait k=%0d got=%b exp=0000", k, {mem_rd, busy, done, err_timeout});
      end
      step;
    end
  endtask

  task automatic test_async_reset;
    start = 1'b1; step; start = 1'b0;
    repeat ($urandom_range(3, 20)) step;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_addr, dog_din, dog_valid, dog_sof, dog_octave, busy, done, err_timeout} !== '0) begin
      failures++; $display("FAIL async_reset got=%h exp=0",
        {mem_rd, mem_addr, dog_din, dog_valid, dog_sof, dog_octave, busy, done, err_timeout});
    end
    step; rst = 1'b1; step;
    checks++;
    if ({mem_rd, busy, done, err_timeout} !== 4'b0000) begin
      failures++; $display("FAIL async_release got=%b exp=0000", {mem_rd, busy, done, err_timeout});
    end
  endtask

  initial begin
    test_reset();
    test_ignore_idle();
    key = 8'h00;
    run_frame(1'b0, 0, 3);
    key = 8'($urandom);
    run_frame(1'b0, 5, TO - 1);
    for (int t = 0; t < 3; t++) begin
      key = 8'($urandom);
      run_frame(1'b1, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end
    test_timeout();
    test_abort(9);
    run_frame(1'b0, 2, 2);
    test_abort($urandom_range(0, 30));
    test_abort_wait();
    test_async_reset();
    key = 8'($urandom);
    run_frame(1'b1, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
